pipeline_stall_ctrl: RTL
========================

# pipeline_stall_ctrl

Pipeline control sequencer that consumes the load-use stall request from hazard detection, the taken-branch pulse from the branch unit, and the data-memory busy flag. It drives the PC and pipeline-register write enables and flushes for the 5-stage RV32 core. It owns all arbitration between stalls, freezes and flushes, plus the pending-flush and stall-watchdog state, so that pipeline registers never see conflicting controls.

## Interface
- MAX_STALL, 2: consecutive load-use stall cycles tolerated before `hazard_error` sets; range 1..15.
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- load_use_stall  in  1  combinational stall request from hazard detection (ID needs a value being loaded in EX).
- branch_taken  in  1  single-cycle pulse from the branch unit in MEM: redirect taken; younger instructions must be squashed.
- mem_busy  in  1  data memory multi-cycle access in progress; whole pipeline must hold.
- pc_write  out  1  PC register write enable.
- if_id_write  out  1  IF/ID register write enable.
- pipe_write  out  1  ID/EX, EX/MEM, MEM/WB write enable.
- if_id_flush  out  1  zero IF/ID (insert NOP).
- id_ex_flush  out  1  zero ID/EX control (bubble).
- ex_mem_flush  out  1  zero EX/MEM control.
- hazard_error  out  1  sticky: stall exceeded MAX_STALL.
- state  out  2  current FSM state, for debug.

## Operation
- States: RUN=0, LU_STALL=1, FREEZE=2; registers: `pending_flush`, 4-bit `stall_cnt`, `hazard_error`.
- Per-cycle priority: rst > mem_busy > (branch_taken or pending_flush) > load_use_stall > normal.
- rst: pc_write=if_id_write=pipe_write=0; all three flushes=1; next state RUN, pending_flush=0, stall_cnt=0, hazard_error=0.
- mem_busy=1: pc_write=if_id_write=pipe_write=0, all flushes 0; next state FREEZE. If branch_taken is seen in this cycle, pending_flush is set to 1. A load_use_stall seen in this cycle is ignored and is re-evaluated after the freeze ends.
- Flush (mem_busy=0 and (branch_taken or pending_flush)): all writes 1; if_id_flush=id_ex_flush=ex_mem_flush=1; pending_flush cleared; stall_cnt cleared; next RUN. The flush overrides a simultaneous load_use_stall, because the stalled instruction is squashed.
- Load-use (mem_busy=0, no flush, load_use_stall=1): pc_write=if_id_write=0, pipe_write=1, id_ex_flush=1, other flushes 0; next LU_STALL; stall_cnt increments and saturates at 15.
  - When the incremented stall_cnt exceeds MAX_STALL, hazard_error is set to 1 and stays set until rst.
- Normal: all writes 1, all flushes 0, stall_cnt cleared, next RUN.
- FREEZE does not clear stall_cnt, so a stall interrupted by a freeze keeps its count.

## Timing
- All outputs except state and hazard_error are combinational from the current inputs, pending_flush and rst. They are valid in the same cycle the request arrives, with zero latency.
- state, stall_cnt, pending_flush and hazard_error are registered and update on the rising edge of clk.
- A load-use hazard normally produces exactly 1 stall cycle: the bubble clears ID/EX MemRead, which drops the request.
- branch_taken arriving during mem_busy: the flush is applied in the first cycle with mem_busy=0. This is exactly one flush cycle, even if branch_taken pulsed more than once while frozen.
- rst asserted mid-freeze or mid-stall discards pending_flush and the counts immediately, at the next edge.

## Configuration
- PIPE_STALL_PERF_EN defined: adds two outputs, `perf_stall_cycles` and `perf_flush_events` (each out, 32 bits).
  - `perf_stall_cycles` increments on every load-use or freeze cycle.
  - `perf_flush_events` increments once per applied flush.
  - Both zero on rst and wrap modulo 2^32.
- PIPE_STALL_PERF_EN undefined: these ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package `pipe_ctrl_pkg`: state enum (RUN, LU_STALL, FREEZE), STATE_W=2, STALL_CNT_W=4, PERF_CNT_W=32.
- One sub-module, `pipe_stall_perf`, holds the two perf counters. It is instantiated only under PIPE_STALL_PERF_EN.

## Test plan
- Reset then idle: rst high for 2 cycles → writes 0 and flushes 1. rst low with no requests → writes 1, flushes 0, state=0, hazard_error=0.
- Single load-use: load_use_stall=1 for 1 cycle → pc_write=if_id_write=0, id_ex_flush=1, state=1 next cycle. Then back to RUN with stall_cnt=0.
- Branch during freeze: mem_busy=1 for 4 cycles, branch_taken pulse in freeze cycle 2 → no flush while busy. In the first cycle after busy drops, all 3 flushes=1, then pending clear.
- Simultaneous branch and load-use with mem_busy=0 → all three flushes=1 and all writes 1, with no stall and stall_cnt=0.
- Watchdog, MAX_STALL=2: load_use_stall held for 3 cycles → hazard_error rises after the 3rd edge and stays 1 after load_use_stall drops, until rst.
- With PIPE_STALL_PERF_EN: 1 load-use stall + 3 freeze cycles + 1 flush → perf_stall_cycles=4, perf_flush_events=1. rst → both 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and widths for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;
  localparam int STATE_W     = 2;
  localparam int STALL_CNT_W = 4;
  localparam int PERF_CNT_W  = 32;

  typedef enum logic [STATE_W-1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FREEZE   = 2'd2
  } state_t;
endpackage

// File: rtl/pipe_stall_perf.sv
// Stall-cycle and flush-event counters; only built with PIPE_STALL_PERF_EN.
module pipe_stall_perf
  import pipe_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_evt,
  input  logic                  flush_evt,
  output logic [PERF_CNT_W-1:0] stall_cycles,
  output logic [PERF_CNT_W-1:0] flush_events
);
  // Counters wrap naturally modulo 2^PERF_CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall_evt) stall_cycles <= stall_cycles + 1'b1;
      if (flush_evt) flush_events <= flush_events + 1'b1;
    end
  end
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Arbitrates mem freeze, branch flush and load-use stall into pipeline enables.
// Optional perf counters are enabled by defining PIPE_STALL_PERF_EN.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_STALL = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_use_stall,
  input  logic               branch_taken,
  input  logic               mem_busy,
  output logic               pc_write,
  output logic               if_id_write,
  output logic               pipe_write,
  output logic               if_id_flush,
  output logic               id_ex_flush,
  output logic               ex_mem_flush,
  output logic               hazard_error,
  output logic [STATE_W-1:0] state
`ifdef PIPE_STALL_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_stall_cycles,
  output logic [PERF_CNT_W-1:0] perf_flush_events
`endif
);
  state_t                 st;
  logic                   pending_flush;
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic [STALL_CNT_W-1:0] cnt_inc;
  logic                   do_flush;
  logic                   do_lu;

  assign state    = st;
  assign do_flush = !mem_busy && (branch_taken || pending_flush);
  assign do_lu    = !mem_busy && !do_flush && load_use_stall;
  assign cnt_inc  = (stall_cnt == '1) ? stall_cnt : stall_cnt + 1'b1;

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    pipe_write   = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    if (rst) begin
      {pc_write, if_id_write, pipe_write}        = 3'b000;
      {if_id_flush, id_ex_flush, ex_mem_flush}   = 3'b111;
    end else if (mem_busy) begin
      {pc_write, if_id_write, pipe_write}        = 3'b000;
    end else if (do_flush) begin
      {if_id_flush, id_ex_flush, ex_mem_flush}   = 3'b111;
    end else if (do_lu) begin
      // Hold PC and IF/ID, let the load advance, bubble into ID/EX.
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st            <= RUN;
      pending_flush <= 1'b0;
      stall_cnt     <= '0;
      hazard_error  <= 1'b0;
    end else if (mem_busy) begin
      // Stall count is kept so a freeze cannot hide a stuck stall.
      st <= FREEZE;
      if (branch_taken) pending_flush <= 1'b1;
    end else if (do_flush) begin
      st            <= RUN;
      pending_flush <= 1'b0;
      stall_cnt     <= '0;
    end else if (do_lu) begin
      st        <= LU_STALL;
      stall_cnt <= cnt_inc;
      if (cnt_inc > STALL_CNT_W'(MAX_STALL)) hazard_error <= 1'b1;
    end else begin
      st        <= RUN;
      stall_cnt <= '0;
    end
  end

`ifdef PIPE_STALL_PERF_EN
  pipe_stall_perf u_perf (
    .clk          (clk),
    .rst          (rst),
    .stall_evt    (!rst && (mem_busy || do_lu)),
    .flush_evt    (!rst && do_flush),
    .stall_cycles (perf_stall_cycles),
    .flush_events (perf_flush_events)
  );
`endif
endmodule
